serial_pattern_gen: RTL and testbench



---
 rtl/serial_pattern_gen.sv | 136 +++++++++++++
 tb/tb_serial_pattern_gen.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_gen.sv
// Serial stimulus transmitter: captures a parallel word on start and shifts it
// out one bit per clock on `a`, qualified by `enable`, followed by an idle gap.
module serial_pattern_gen #(
    parameter int   DATA_W     = 8,
    parameter int   GAP        = 2,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    input  logic              pause,
    output logic              ready,
    output logic              busy,
    output logic              a,
    output logic              enable,
    output logic              done
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] BITS_ALL = CW'(DATA_W);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              a_q, a_d;
    logic              enable_q, enable_d;
    logic              done_q, done_d;

    function automatic logic head(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? v[DATA_W-1] : v[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] v);
        return (MSB_FIRST != 0) ? {v[DATA_W-2:0], 1'b0} : {1'b0, v[DATA_W-1:1]};
    endfunction

    // cnt_q counts bits already presented; the shift register's head is the
    // pending bit, which is what `a` shows while paused.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        a_d      = a_q;
        enable_d = enable_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                a_d      = IDLE_LEVEL;
                enable_d = 1'b0;
                if (start) begin
                    state_d  = S_SHIFT;
                    shift_d  = advance(data);
                    cnt_d    = CW'(1);
                    a_d      = head(data);
                    enable_d = 1'b1;
                end
            end
            S_SHIFT: begin
                if (pause) begin
                    enable_d = 1'b0;
                    if (cnt_q != BITS_ALL) begin
                        a_d = head(shift_q);
                    end
                end else if (cnt_q == BITS_ALL) begin
                    enable_d = 1'b0;
                    a_d      = IDLE_LEVEL;
                    if (GAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    a_d      = head(shift_q);
                    enable_d = 1'b1;
                    shift_d  = advance(shift_q);
                    cnt_d    = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                a_d      = IDLE_LEVEL;
                enable_d = 1'b0;
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                a_d      = IDLE_LEVEL;
                enable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            a_q      <= IDLE_LEVEL;
            enable_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            a_q      <= a_d;
            enable_q <= enable_d;
            done_q   <= done_d;
        end
    end

    assign ready  = (state_q == S_IDLE);
    assign busy   = ~ready;
    assign a      = a_q;
    assign enable = enable_q;
    assign done   = done_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Scoreboard bench: two configurations (MSB-first with gap, LSB-first without gap)
// driven by directed and random frames; a monitor checks every output cycle.
module tb_serial_pattern_gen;
    localparam int DW = 8;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   fin [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_cfg
        localparam int GP = (gi == 0) ? 2 : 0;
        localparam int MF = (gi == 0) ? 1 : 0;

        logic          rst, start, pause, ready, busy, a, enable, done;
        logic [DW-1:0] data;
        logic          exp_bits[$];
        int            exp_done[$];

        serial_pattern_gen #(
            .DATA_W(DW), .GAP(GP), .MSB_FIRST(MF), .IDLE_LEVEL(1'b1)
        ) u_dut (
            .clock(clk), .reset(rst), .start(start), .data(data), .pause(pause),
            .ready(ready), .busy(busy), .a(a), .enable(enable), .done(done)
        );

        // pmode: 0 none, 1 random, 2 three pauses before bit 3
        // jmode: 0 none, 1 random start/data, 2 start held high, 3 start 8'hFF at bit 4
        task automatic send_frame(input logic [DW-1:0] w, input int pmode, input int jmode);
            int e, u, p;
            start = 1'b1;
            data  = w;
            pause = ($urandom_range(0, 1) == 1);
            tick();
            e = cyc;
            for (int k = 0; k < DW; k++) exp_bits.push_back((MF != 0) ? w[DW-1-k] : w[k]);
            u = 0;
            p = 0;
            while (u < DW) begin
                case (pmode)
                    1:       pause = ($urandom_range(0, 3) == 0);
                    2:       pause = (u == 2 && p < 3);
                    default: pause = 1'b0;
                endcase
                case (jmode)
                    1:       begin start = ($urandom_range(0, 1) == 1); data = DW'($urandom); end
                    2:       start = 1'b1;
                    3:       begin start = (u == 3 && !pause); data = 8'hFF; end
                    default: start = 1'b0;
                endcase
                tick();
                if (pause) p++;
                else u++;
            end
            exp_done.push_back(e + DW + GP + p);
            for (int g = 0; g < GP; g++) begin
                pause = (pmode == 1) && ($urandom_range(0, 1) == 1);
                start = (jmode == 2) || ((jmode == 1) && ($urandom_range(0, 1) == 1));
                data  = DW'($urandom);
                tick();
            end
            start = 1'b0;
            pause = 1'b0;
        endtask

        task automatic idle(input int n);
            start = 1'b0;
            repeat (n) tick();
        endtask

        initial begin
            rst   = 1'b1;
            start = 1'b0;
            pause = 1'b0;
            data  = '0;
            #7;
            chk($sformatf("cfg%0d_rst_ready", gi), int'(ready), 1);
            chk($sformatf("cfg%0d_rst_busy", gi), int'(busy), 0);
            chk($sformatf("cfg%0d_rst_a", gi), int'(a), 1);
            chk($sformatf("cfg%0d_rst_enable", gi), int'(enable), 0);
            chk($sformatf("cfg%0d_rst_done", gi), int'(done), 0);
            #5 rst = 1'b0;
            tick();
            send_frame(8'hA5, 0, 0);
            idle(2);
            send_frame(8'h0F, 0, 0);
            idle(1);
            send_frame(8'hA5, 2, 0);
            idle(1);
            send_frame(8'h3C, 0, 3);
            idle(2);
            // abort a frame with an asynchronous reset while bit 5 is on the line
            start = 1'b1;
            data  = 8'h96;
            tick();
            start = 1'b0;
            for (int k = 0; k < DW; k++) exp_bits.push_back((MF != 0) ? data[DW-1-k] : data[k]);
            repeat (5) tick();
            #2 rst = 1'b1;
            exp_bits.delete();
            exp_done.delete();
            #1;
            chk($sformatf("cfg%0d_abort_a", gi), int'(a), 1);
            chk($sformatf("cfg%0d_abort_enable", gi), int'(enable), 0);
            chk($sformatf("cfg%0d_abort_busy", gi), int'(busy), 0);
            chk($sformatf("cfg%0d_abort_ready", gi), int'(ready), 1);
            chk($sformatf("cfg%0d_abort_done", gi), int'(done), 0);
            @(posedge clk);
            #2 rst = 1'b0;
            tick();
            send_frame(8'h5A, 0, 0);
            // start held high: frames back-to-back
            for (int f = 0; f < 4; f++) send_frame(8'hC3, 0, 2);
            idle(1);
            for (int f = 0; f < 40; f++) begin
                send_frame(DW'($urandom), 1, 1);
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            end
            idle(5);
            chk($sformatf("cfg%0d_bits_left", gi), exp_bits.size(), 0);
            chk($sformatf("cfg%0d_done_left", gi), exp_done.size(), 0);
            fin[gi] = 1'b1;
        end

        always @(negedge clk) begin
            if (enable) begin
                if (exp_bits.size() == 0) chk($sformatf("cfg%0d_unexpected_enable", gi), 1, 0);
                else chk($sformatf("cfg%0d_bit", gi), int'(a), int'(exp_bits.pop_front()));
            end else if (busy && exp_bits.size() > 0) begin
                chk($sformatf("cfg%0d_pause_bit", gi), int'(a), int'(exp_bits[0]));
            end
            if (!busy) begin
                chk($sformatf("cfg%0d_idle_a", gi), int'(a), 1);
                chk($sformatf("cfg%0d_ready", gi), int'(ready), 1);
            end
            if (done) begin
                chk($sformatf("cfg%0d_done_busy", gi), int'(busy), 0);
                if (exp_done.size() == 0) chk($sformatf("cfg%0d_unexpected_done", gi), 1, 0);
                else chk($sformatf("cfg%0d_done_cycle", gi), cyc, exp_done.pop_front());
            end
        end
    end

    initial begin
        wait (fin[0] && fin[1]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        checks++;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
